// File: rtl/cardinal_pkg.sv
// Shared defaults and FSM encoding for the cardinal_processor data-memory responder.
package cardinal_pkg;

  localparam int unsigned CARD_DATA_W = 64;
  localparam int unsigned CARD_ADDR_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/cardinal_dmem_array.sv
// DEPTH x DATA_W single-write / single-registered-read storage, block-RAM shaped.
module dmem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [0:ADDR_W-1] waddr,
  input  logic [0:DATA_W-1] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [0:ADDR_W-1] raddr,
  output logic [0:DATA_W-1] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [0:DATA_W-1] r_mem [DEPTH];

  // Storage itself carries no reset; the owner scrubs it through the write port.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/cardinal_dmem.sv
// Data-memory responder for cardinal_processor: scrub-after-reset FSM, processor
// port and a boot load port arbitrated onto a single-port array.
module cardinal_dmem
  import cardinal_pkg::*;
#(
  parameter int unsigned DATA_W = CARD_DATA_W,
  parameter int unsigned ADDR_W = CARD_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [0:ADDR_W-1] Mem_Addr,
  input  logic [0:DATA_W-1] Mem_Wdata,
  input  logic              DmemEn,
  input  logic              DmemWrEn,
  output logic [0:DATA_W-1] Mem_Rdata,
  input  logic              Ld_Valid,
  input  logic [0:ADDR_W-1] Ld_Addr,
  input  logic [0:DATA_W-1] Ld_Data,
  output logic              Ld_Ready,
  output logic              Mem_Ready,
  output logic              Access_Err
);

  dmem_state_t       r_state, w_state_nxt;
  logic [0:ADDR_W-1] r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;

  logic              w_we, w_re, w_rclr;
  logic [0:ADDR_W-1] w_waddr;
  logic [0:DATA_W-1] w_wdata;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Single port: scrub owns it in CLEAR; in READY the processor wins over the load port.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_re        = 1'b0;
    w_rclr      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == '1) w_state_nxt = READY;
        w_err_nxt = DmemEn;
        w_rclr    = DmemEn && !DmemWrEn;
      end
      READY: begin
        if (DmemEn) begin
          if (DmemWrEn) begin
            w_we    = 1'b1;
            w_waddr = Mem_Addr;
            w_wdata = Mem_Wdata;
          end else begin
            w_re = 1'b1;
          end
        end else if (Ld_Valid) begin
          w_we    = 1'b1;
          w_waddr = Ld_Addr;
          w_wdata = Ld_Data;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign Ld_Ready   = (r_state == READY) && !DmemEn;
  assign Mem_Ready  = (r_state == READY);
  assign Access_Err = r_err;

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (Clock),
    .rst_n(Reset),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(w_wdata),
    .re   (w_re),
    .rclr (w_rclr),
    .raddr(Mem_Addr),
    .rdata(Mem_Rdata)
  );

endmodule

// File: tb/tb_cardinal_dmem.sv
// Directed bench for cardinal_dmem: scrub timing, read/write latency, load-port
// arbitration, access during scrub and reset mid-scrub.
module tb_cardinal_dmem;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [0:7]  Mem_Addr;
  logic [0:63] Mem_Wdata;
  logic        DmemEn;
  logic        DmemWrEn;
  logic [0:63] Mem_Rdata;
  logic        Ld_Valid;
  logic [0:7]  Ld_Addr;
  logic [0:63] Ld_Data;
  logic        Ld_Ready;
  logic        Mem_Ready;
  logic        Access_Err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 Clock = ~Clock;

  cardinal_dmem #(
    .DATA_W(64),
    .ADDR_W(8)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .DmemEn    (DmemEn),
    .DmemWrEn  (DmemWrEn),
    .Mem_Rdata (Mem_Rdata),
    .Ld_Valid  (Ld_Valid),
    .Ld_Addr   (Ld_Addr),
    .Ld_Data   (Ld_Data),
    .Ld_Ready  (Ld_Ready),
    .Mem_Ready (Mem_Ready),
    .Access_Err(Access_Err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    DmemEn   = 1'b0;
    DmemWrEn = 1'b0;
  endtask

  task automatic pwrite(input logic [7:0] a, input logic [63:0] d);
    Mem_Addr  = a;
    Mem_Wdata = d;
    DmemEn    = 1'b1;
    DmemWrEn  = 1'b1;
    tick();
    idle();
  endtask

  task automatic pread(input logic [7:0] a);
    Mem_Addr = a;
    DmemEn   = 1'b1;
    DmemWrEn = 1'b0;
    tick();
    idle();
  endtask

  task automatic wait_ready(output int unsigned n);
    n = 0;
    while (!Mem_Ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    logic [63:0] prev;

    Reset     = 1'b0;
    Mem_Addr  = '0;
    Mem_Wdata = '0;
    DmemEn    = 1'b0;
    DmemWrEn  = 1'b0;
    Ld_Valid  = 1'b0;
    Ld_Addr   = '0;
    Ld_Data   = '0;
    tick();
    tick();
    check("rst_rdata", Mem_Rdata, 64'h0);
    check("rst_ready", {63'h0, Mem_Ready}, 64'h0);
    check("rst_ldready", {63'h0, Ld_Ready}, 64'h0);
    check("rst_err", {63'h0, Access_Err}, 64'h0);

    // 1: scrub length and zeroed contents
    Reset = 1'b1;
    wait_ready(n);
    check("scrub_cycles", 64'(n), 64'd256);
    pread(8'h00); check("rd_00", Mem_Rdata, 64'h0);
    pread(8'h7F); check("rd_7f", Mem_Rdata, 64'h0);
    pread(8'hFF); check("rd_ff", Mem_Rdata, 64'h0);

    // 2: write then immediate read
    prev = Mem_Rdata;
    pwrite(8'h10, 64'hDEADBEEF_CAFEF00D);
    check("wr_holds_rdata", Mem_Rdata, 64'h0);
    pread(8'h10);
    check("rd_10", Mem_Rdata, 64'hDEADBEEF_CAFEF00D);

    // 3: load port blocked while processor active
    Ld_Valid = 1'b1;
    Ld_Addr  = 8'h20;
    Ld_Data  = 64'h1;
    Mem_Addr = 8'h10;
    DmemEn   = 1'b1;
    DmemWrEn = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ldready_blk%0d", i), {63'h0, Ld_Ready}, 64'h0);
      tick();
    end
    idle();
    #1;
    check("ldready_open", {63'h0, Ld_Ready}, 64'h1);
    tick();
    Ld_Valid = 1'b0;
    check("ld_keeps_rdata", Mem_Rdata, 64'hDEADBEEF_CAFEF00D);
    pread(8'h20);
    check("rd_20", Mem_Rdata, 64'h1);

    // 6: rdata held while disabled; stray DmemWrEn ignored
    pread(8'h10);
    check("rd_10_again", Mem_Rdata, 64'hDEADBEEF_CAFEF00D);
    Mem_Addr  = 8'h10;
    Mem_Wdata = 64'h0123_4567_89AB_CDEF;
    for (int unsigned i = 0; i < 4; i++) begin
      DmemWrEn = i[0];
      tick();
      check($sformatf("hold%0d", i), Mem_Rdata, 64'hDEADBEEF_CAFEF00D);
    end
    idle();
    pread(8'h20);
    pread(8'h10);
    check("rd_10_unchanged", Mem_Rdata, 64'hDEADBEEF_CAFEF00D);

    // 4: processor write during scrub is rejected
    Reset = 1'b0;
    tick();
    check("rst2_rdata", Mem_Rdata, 64'h0);
    Reset = 1'b1;
    n = 0;
    while (!Mem_Ready && n < 400) begin
      if (n == 49) begin
        Mem_Addr  = 8'h05;
        Mem_Wdata = 64'hFF;
        DmemEn    = 1'b1;
        DmemWrEn  = 1'b1;
      end else begin
        idle();
      end
      tick();
      n++;
      if (n == 50) check("err_pulse", {63'h0, Access_Err}, 64'h1);
      if (n == 51) check("err_clear", {63'h0, Access_Err}, 64'h0);
    end
    idle();
    check("scrub_cycles2", 64'(n), 64'd256);
    pread(8'h05);
    check("rd_05_dropped", Mem_Rdata, 64'h0);

    // 5: reset mid-scrub restarts it
    pwrite(8'hFF, 64'hA5);
    pread(8'hFF);
    check("rd_ff_a5", Mem_Rdata, 64'hA5);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    for (int unsigned i = 0; i < 100; i++) tick();
    check("midscrub_notready", {63'h0, Mem_Ready}, 64'h0);
    Reset = 1'b0;
    tick();
    check("midscrub_rst_ready", {63'h0, Mem_Ready}, 64'h0);
    Reset = 1'b1;
    wait_ready(n);
    check("scrub_cycles3", 64'(n), 64'd256);
    pread(8'hFF);
    check("rd_ff_scrubbed", Mem_Rdata, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
